// File: rtl/multicycle_controller.sv
// Purpose : main control FSM of the multicycle RV32I core; drives every datapath select/enable.
// Latency : MEM_RD_WAIT=1 -> branch 5, R/I/LUI/AUIPC/store/JAL 6, JALR 7, load 8 cycles.
// Backpress: none; one state per cycle, memory assumed to answer after MEM_RD_WAIT extra cycles.
//
// Ports:
//   clk, reset (async, active-high)
//   op_code/funct3/funct7       instruction fields from the IR
//   Zero/ALUResultLSB           ALU status used to resolve branches
//   adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
//   alu_src_a, alu_src_b, imm_src, alu_control   datapath controls
//   instr_retire, retire_count  retire pulse and wrapping retire counter
//   illegal                     sticky illegal-opcode flag
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes
// (default: unknown opcodes retire as a NOP and illegal reads 0).
module multicycle_controller #(
    parameter int MEM_RD_WAIT  = 1,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              op_code,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    input  logic                    Zero,
    input  logic                    ALUResultLSB,
    output logic                    adr_src,
    output logic                    mem_write,
    output logic                    IR_write,
    output logic                    reg_write,
    output logic                    PC_write,
    output logic [1:0]              result_src,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [2:0]              imm_src,
    output logic [3:0]              alu_control,
    output logic                    instr_retire,
    output logic [RETIRE_CNT_W-1:0] retire_count,
    output logic                    illegal
);

    typedef enum logic [4:0] {
        S_FETCH, S_FETCH_W, S_FETCH2, S_DECODE,
        S_MEMADR, S_MEMREAD, S_MEMWAIT, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_EXEC_LUI, S_EXEC_AUIPC, S_ALUWB,
        S_BRANCH, S_JAL_LINK, S_EXEC_JALR, S_JALR_LINK, S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    state_t                  state_q, state_d;
    logic [RETIRE_CNT_W-1:0] retire_count_q;

    // Only funct7[5] distinguishes SUB/SRA; the other bits are immediate or reserved.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Arithmetic decode shared by R- and I-type; allow_sub is false for I-type
    // because funct7 there is part of the immediate except for shifts.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7b5,
                                            input logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        state_d      = state_q;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        IR_write     = 1'b0;
        reg_write    = 1'b0;
        PC_write     = 1'b0;
        result_src   = 2'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        imm_src      = IMM_I;
        alu_control  = ALU_ADD;
        instr_retire = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d = (MEM_RD_WAIT != 0) ? S_FETCH_W : S_FETCH2;
            end
            S_FETCH_W: begin
                state_d = S_FETCH2;
            end
            S_FETCH2: begin
                // PC <= PC+4 on the same edge the IR/old_PC capture the fetched word.
                IR_write   = 1'b1;
                PC_write   = 1'b1;
                result_src = 2'd2;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Precompute old_PC + imm so ALU_out holds the branch/jump target.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = (op_code == OP_JAL) ? IMM_J : IMM_B;
                case (op_code)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL_LINK;
                    OP_JALR:           state_d = S_EXEC_JALR;
                    OP_LUI:            state_d = S_EXEC_LUI;
                    OP_AUIPC:          state_d = S_EXEC_AUIPC;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        instr_retire = 1'b1;
                        state_d      = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR, S_MEMREAD, S_MEMWAIT, S_MEMWRITE: begin
                // Address computation stays on the ALU so ALU_out cannot drift
                // while memory is being accessed.
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (op_code == OP_STORE) ? IMM_S : IMM_I;
                case (state_q)
                    S_MEMADR:  state_d = (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                    S_MEMREAD: begin
                        adr_src = 1'b1;
                        state_d = (MEM_RD_WAIT != 0) ? S_MEMWAIT : S_MEMWB;
                    end
                    S_MEMWAIT: begin
                        adr_src = 1'b1;
                        state_d = S_MEMWB;
                    end
                    default: begin
                        adr_src      = 1'b1;
                        mem_write    = 1'b1;
                        instr_retire = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                result_src   = 2'd1;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'd2;
                alu_control = arith_op(funct3, funct7[5], 1'b1);
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                alu_control = arith_op(funct3, funct7[5], 1'b0);
                state_d     = S_ALUWB;
            end
            S_EXEC_LUI, S_EXEC_AUIPC: begin
                alu_src_a = (state_q == S_EXEC_LUI) ? 2'd3 : 2'd1;
                alu_src_b = 2'd1;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                // Compare rs1/rs2 and load the precomputed target only when taken.
                alu_src_a    = 2'd2;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  PC_write = Zero;          end
                    3'b001: begin alu_control = ALU_SUB;  PC_write = !Zero;         end
                    3'b100: begin alu_control = ALU_SLT;  PC_write = ALUResultLSB;  end
                    3'b101: begin alu_control = ALU_SLT;  PC_write = !ALUResultLSB; end
                    3'b110: begin alu_control = ALU_SLTU; PC_write = ALUResultLSB;  end
                    3'b111: begin alu_control = ALU_SLTU; PC_write = !ALUResultLSB; end
                    default: begin alu_control = ALU_SUB; PC_write = 1'b0;          end
                endcase
            end
            S_JAL_LINK: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd1;
                imm_src    = IMM_J;
                reg_write  = 1'b1;
                result_src = 2'd3;
                state_d    = S_JUMP;
            end
            S_EXEC_JALR, S_JALR_LINK: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                if (state_q == S_JALR_LINK) begin
                    reg_write  = 1'b1;
                    result_src = 2'd3;
                    state_d    = S_JUMP;
                end else begin
                    state_d    = S_JALR_LINK;
                end
            end
            S_JUMP: begin
                // Keep the ALU inputs of the link state; JAL and JALR differ in base and imm.
                alu_src_a    = (op_code == OP_JAL) ? 2'd1 : 2'd2;
                alu_src_b    = 2'd1;
                imm_src      = (op_code == OP_JAL) ? IMM_J : IMM_I;
                PC_write     = 1'b1;
                instr_retire = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                // S_TRAP: everything idle until reset.
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_FETCH;
            retire_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_retire) begin
                retire_count_q <= retire_count_q + RETIRE_CNT_W'(1);
            end
        end
    end

    assign retire_count = retire_count_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state_d == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose : scoreboard bench for multicycle_controller; per-cycle expected control words.
// Latency : expected sequences are built per instruction class from the ISA-level rules.
// Backpress: none; the monitor compares every cycle that has a queued expectation.
module tb_multicycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    op_code;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          Zero;
    logic          ALUResultLSB;
    logic          adr_src, mem_write, IR_write, reg_write, PC_write;
    logic [1:0]    result_src, alu_src_a, alu_src_b;
    logic [2:0]    imm_src;
    logic [3:0]    alu_control;
    logic          instr_retire;
    logic [CW-1:0] retire_count;
    logic          illegal;

    multicycle_controller #(.MEM_RD_WAIT(1), .RETIRE_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .ALUResultLSB(ALUResultLSB), .adr_src(adr_src), .mem_write(mem_write),
        .IR_write(IR_write), .reg_write(reg_write), .PC_write(PC_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .instr_retire(instr_retire),
        .retire_count(retire_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       adr_src, mem_write, ir_write, reg_write, pc_write;
        logic [1:0] result_src, src_a, src_b;
        logic [2:0] imm_src;
        logic [3:0] alu;
        logic       retire;
        logic       care_alu;
    } ctl_t;

    typedef struct packed {
        ctl_t          ctl;
        logic [CW-1:0] count;
        logic          illegal;
    } exp_t;

    typedef enum {K_R, K_I, K_LUI, K_AUIPC, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_BAD} kind_t;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_cyc   = 0;
    logic [CW-1:0] m_count = '0;
    logic          m_illegal = 1'b0;
    exp_t          mon_e;
    ctl_t          mon_a;

    function automatic ctl_t blank();
        ctl_t c = '0;
        c.care_alu = 1'b1;
        return c;
    endfunction

    function automatic logic [6:0] opc(input kind_t k);
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LUI:   return 7'b0110111;
            K_AUIPC: return 7'b0010111;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            default: return 7'h7F;
        endcase
    endfunction

    // ALU op of an R/I arithmetic instruction, straight from the ISA table.
    function automatic logic [3:0] arith(input logic [2:0] f3, input logic f7b5, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7b5) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f7b5 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic push(input ctl_t c);
        exp_t e;
        e.ctl     = c;
        e.count   = m_count;
        e.illegal = m_illegal;
        exp_q.push_back(e);
        if (c.retire) m_count = m_count + 1'b1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        m_count   = '0;
        m_illegal = 1'b0;
        push(blank());
        push(blank());
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Drive one instruction, queue its expected per-cycle controls (optionally
    // only the first 'limit' cycles) and wait that many cycles.
    task automatic issue(input kind_t k, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic lsb, input int limit);
        ctl_t seq[$];
        ctl_t c, base;
        int   n;
        op_code = opc(k); funct3 = f3; funct7 = f7; Zero = z; ALUResultLSB = lsb;
        // fetch address phase plus one memory wait cycle
        seq.push_back(blank());
        seq.push_back(blank());
        c = blank(); c.ir_write = 1; c.pc_write = 1; c.result_src = 2; seq.push_back(c);
        c = blank(); c.src_a = 1; c.src_b = 1; c.imm_src = (k == K_JAL) ? 3'd3 : 3'd2;
`ifndef CTRL_ILLEGAL_TRAP_EN
        if (k == K_BAD) c.retire = 1;
`endif
        seq.push_back(c);
        case (k)
            K_R, K_I: begin
                c = blank(); c.src_a = 2; c.src_b = (k == K_I) ? 2'd1 : 2'd0;
                c.alu = arith(f3, f7[5], k == K_R); seq.push_back(c);
                c = blank(); c.reg_write = 1; c.retire = 1; seq.push_back(c);
            end
            K_LUI, K_AUIPC: begin
                c = blank(); c.src_a = (k == K_LUI) ? 2'd3 : 2'd1; c.src_b = 1; c.imm_src = 4;
                seq.push_back(c);
                c = blank(); c.reg_write = 1; c.retire = 1; seq.push_back(c);
            end
            K_LD: begin
                base = blank(); base.src_a = 2; base.src_b = 1; base.imm_src = 0;
                seq.push_back(base);
                c = base; c.adr_src = 1; seq.push_back(c); seq.push_back(c);
                c = blank(); c.reg_write = 1; c.result_src = 1; c.retire = 1; seq.push_back(c);
            end
            K_ST: begin
                base = blank(); base.src_a = 2; base.src_b = 1; base.imm_src = 1;
                seq.push_back(base);
                c = base; c.adr_src = 1; c.mem_write = 1; c.retire = 1; seq.push_back(c);
            end
            K_BR: begin
                c = blank(); c.src_a = 2; c.retire = 1;
                case (f3)
                    3'd0: begin c.alu = 1; c.pc_write = z;    end
                    3'd1: begin c.alu = 1; c.pc_write = !z;   end
                    3'd4: begin c.alu = 5; c.pc_write = lsb;  end
                    3'd5: begin c.alu = 5; c.pc_write = !lsb; end
                    3'd6: begin c.alu = 6; c.pc_write = lsb;  end
                    3'd7: begin c.alu = 6; c.pc_write = !lsb; end
                    default: c.care_alu = 0;
                endcase
                seq.push_back(c);
            end
            K_JAL, K_JALR: begin
                base = blank(); base.src_b = 1;
                if (k == K_JAL) begin
                    base.src_a = 1; base.imm_src = 3;
                end else begin
                    base.src_a = 2; base.imm_src = 0;
                    seq.push_back(base);
                end
                c = base; c.reg_write = 1; c.result_src = 3; seq.push_back(c);
                c = base; c.pc_write = 1; c.retire = 1; seq.push_back(c);
            end
            default: ;
        endcase
        n = (limit < 0 || limit > seq.size()) ? seq.size() : limit;
        for (int i = 0; i < n; i++) push(seq[i]);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input kind_t k, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic lsb);
        issue(k, f3, f7, z, lsb, -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (k == K_BAD) begin
            m_illegal = 1'b1;
            repeat (3) push(blank());
            repeat (3) @(posedge clk);
            #1 do_reset();
        end
`endif
    endtask

    always @(negedge clk) begin
        n_cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a.adr_src    = adr_src;
            mon_a.mem_write  = mem_write;
            mon_a.ir_write   = IR_write;
            mon_a.reg_write  = reg_write;
            mon_a.pc_write   = PC_write;
            mon_a.result_src = result_src;
            mon_a.src_a      = alu_src_a;
            mon_a.src_b      = alu_src_b;
            mon_a.imm_src    = imm_src;
            mon_a.alu        = mon_e.ctl.care_alu ? alu_control : mon_e.ctl.alu;
            mon_a.retire     = instr_retire;
            mon_a.care_alu   = mon_e.ctl.care_alu;
            n_tests++;
            if (mon_a !== mon_e.ctl) begin
                n_fail++;
                $display("FAIL ctrl cycle %0d op=%b f3=%0d: got %h, expected %h",
                         n_cyc, op_code, funct3, mon_a, mon_e.ctl);
            end
            n_tests++;
            if (retire_count !== mon_e.count) begin
                n_fail++;
                $display("FAIL retire_count cycle %0d: got %0d, expected %0d",
                         n_cyc, retire_count, mon_e.count);
            end
            n_tests++;
            if (illegal !== mon_e.illegal) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got %b, expected %b",
                         n_cyc, illegal, mon_e.illegal);
            end
        end
    end

    initial begin
        reset = 1'b1;
        op_code = '0; funct3 = '0; funct7 = '0; Zero = 1'b0; ALUResultLSB = 1'b0;
        @(posedge clk);
        #1 do_reset();

        run(K_R,    3'd0, 7'h00, 0, 0);   // add
        run(K_R,    3'd0, 7'h20, 0, 0);   // sub
        run(K_I,    3'd5, 7'h20, 0, 0);   // srai
        run(K_R,    3'd2, 7'h00, 0, 0);   // slt
        run(K_I,    3'd0, 7'h20, 0, 0);   // addi, funct7[5] ignored
        run(K_LD,   3'd2, 7'h00, 0, 0);   // lw
        run(K_ST,   3'd2, 7'h00, 0, 0);   // sw
        run(K_BR,   3'd0, 7'h00, 1, 0);   // beq taken
        run(K_BR,   3'd0, 7'h00, 0, 0);   // beq not taken
        run(K_BR,   3'd6, 7'h00, 0, 1);   // bltu taken
        run(K_BR,   3'd2, 7'h00, 1, 1);   // reserved funct3, never taken
        run(K_JAL,  3'd0, 7'h00, 0, 0);
        run(K_JALR, 3'd0, 7'h00, 0, 0);
        run(K_LUI,  3'd0, 7'h00, 0, 0);
        run(K_AUIPC, 3'd0, 7'h00, 0, 0);
        run(K_BAD,  3'd0, 7'h00, 0, 0);   // opcode 0x7F

        // abandon a load mid-flight, then show clean restart
        issue(K_LD, 3'd2, 7'h00, 0, 0, 5);
        do_reset();
        run(K_R, 3'd0, 7'h00, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run(kind_t'($urandom_range(0, 9)), 3'($urandom_range(0, 7)),
                7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
